// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and default PC/memory sizing
// constants, also used to size the program memory.
package instruction_fetch_pkg;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    localparam int unsigned      DEFAULT_PC_W      = 32;
    localparam int unsigned      DEFAULT_INSTR_W   = 32;
    localparam int unsigned      DEFAULT_RESET_PC  = 0;
    localparam longint unsigned  DEFAULT_MEM_DEPTH = 65536;

    // True when a word address lies inside the populated program memory.
    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with hold / increment / redirect selection and the
// memory-depth range compare on the current PC.
module instruction_fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     PC_W      = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEFAULT_RESET_PC),
    parameter longint unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic            in_range
);

    localparam logic [63:0] DEPTH64 = 64'(MEM_DEPTH);

    logic [PC_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (step) begin
            pc_next = pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Zero-extend so depths at or above 2^PC_W simply make every PC legal.
    assign in_range = addr_in_range(64'(pc), DEPTH64);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational program memory and presents
// (pc, instr) to decode over valid/ready. Optional counters under IFETCH_PERF_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     PC_W      = DEFAULT_PC_W,
    parameter int unsigned     INSTR_W   = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEFAULT_RESET_PC),
    parameter longint unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_adr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    output logic               fault
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalled
`endif
);

    // Handshake: a word moves to decode on every rising edge where out_valid and
    // out_ready are both high; out_valid only falls after such a transfer, on a
    // redirect (which squashes the held word) or on reset.

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic            in_range;
    logic            adv;
    logic            capture;

    assign adv     = (state == FETCH_RUN) && (!out_valid || out_ready) && !redirect_valid;
    assign capture = adv && in_range;

    instruction_fetch_pc_reg #(
        .PC_W      (PC_W),
        .RESET_PC  (RESET_PC),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .step           (capture),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .in_range       (in_range)
    );

    assign imem_adr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_RUN;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
        end else if (redirect_valid) begin
            // The target is fetched on the following edge, leaving a one-cycle bubble.
            state     <= FETCH_RUN;
            out_valid <= 1'b0;
            fault     <= 1'b0;
        end else if (adv) begin
            if (in_range) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
                out_valid <= 1'b1;
            end else begin
                state     <= FETCH_FAULT;
                out_valid <= 1'b0;
                fault     <= 1'b1;
            end
        end else if (state == FETCH_FAULT) begin
            out_valid <= 1'b0;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
        end else begin
            if (capture && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready && (perf_stalled != '1)) begin
                perf_stalled <= perf_stalled + 32'd1;
            end
        end
    end
`endif

    a_stall_holds: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !redirect_valid)
        |=> (out_valid && $stable(out_instr) && $stable(out_pc)));

    a_fault_no_valid: assert property (@(posedge clk) disable iff (rst)
        (state == FETCH_FAULT) |-> !out_valid);

    a_fault_matches_state: assert property (@(posedge clk) disable iff (rst)
        fault == (state == FETCH_FAULT));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written latency/perf
// sequences and a randomized run against a cycle-level reference model.
module tb_instruction_fetch;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 8;

    logic               clk;
    logic               rst;
    logic [PC_W-1:0]    imem_adr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;
    logic               fault;
`ifdef IFETCH_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stalled;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (16'd0),
        .MEM_DEPTH (64'(DEPTH))
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_adr       (imem_adr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fault          (fault)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalled   (perf_stalled)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents: word n holds 0xA0+n; beyond that, a recognisable pattern.
    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        if (a < 16) return 32'hA0 + 32'(a);
        return 32'hBAD0_0000 | 32'(a);
    endfunction

    assign imem_instr = mem_word(imem_adr);

    // Reference model of the stage, advanced once per cycle from the rules.
    logic [PC_W-1:0]    m_pc;
    logic               m_valid;
    logic [PC_W-1:0]    m_opc;
    logic [INSTR_W-1:0] m_instr;
    logic               m_fault;
    logic [31:0]        m_fetched;
    logic [31:0]        m_stalled;

    task automatic model_step(input logic r, input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
        if (r) begin
            m_pc = '0; m_valid = 0; m_opc = '0; m_instr = '0; m_fault = 0;
            m_fetched = 0; m_stalled = 0;
        end else begin
            if (m_valid && !rdy && m_stalled != 32'hFFFF_FFFF) m_stalled++;
            if (rv) begin
                m_pc = rpc; m_valid = 0; m_fault = 0;
            end else if (!m_fault && (!m_valid || rdy)) begin
                if (int'(m_pc) < DEPTH) begin
                    m_opc = m_pc; m_instr = mem_word(m_pc); m_valid = 1;
                    m_pc = m_pc + 1'b1;
                    if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
                end else begin
                    m_valid = 0; m_fault = 1;
                end
            end
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        model_step(r, rdy, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic               r;
        logic               rdy;
        logic               rv;
        logic [PC_W-1:0]    rpc;
        logic               ev;
        logic               cd;
        logic [PC_W-1:0]    epc;
        logic [INSTR_W-1:0] ei;
        logic [PC_W-1:0]    eadr;
        logic               ef;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rdy, input logic rv, input int rpc,
                                input logic ev, input logic cd, input int epc, input int ei,
                                input int eadr, input logic ef);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rv = rv; v.rpc = PC_W'(rpc);
        v.ev = ev; v.cd = cd; v.epc = PC_W'(epc); v.ei = INSTR_W'(ei);
        v.eadr = PC_W'(eadr); v.ef = ef;
        vecs.push_back(v);
    endfunction

    initial begin
        int lat;
        rst = 1; out_ready = 0; redirect_valid = 0; redirect_pc = '0;

        // Reset clears everything, then streaming with stall, redirect, rst, fault.
        add(1,0,0,0, 0,1,0,0,0,0);
        add(1,0,0,0, 0,1,0,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0, 1,1,i,'hA0+i,i+1,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 1,1,2,'hA2,3,0);
        add(0,1,0,0, 1,1,3,'hA3,4,0);
        add(0,1,0,0, 1,1,4,'hA4,5,0);
        add(0,1,1,1, 0,0,0,0,1,0);
        for (int i = 1; i < 6; i++) add(0,1,0,0, 1,1,i,'hA0+i,i+1,0);
        add(0,0,0,0, 1,1,5,'hA5,6,0);
        add(1,0,0,0, 0,1,0,0,0,0);
        for (int i = 0; i < 8; i++) add(0,1,0,0, 1,1,i,'hA0+i,i+1,0);
        add(0,1,0,0, 0,0,0,0,8,1);
        add(0,1,0,0, 0,0,0,0,8,1);
        add(0,1,1,0, 0,0,0,0,0,0);
        add(0,1,0,0, 1,1,0,'hA0,1,0);
        add(0,1,1,9, 0,0,0,0,9,0);
        add(0,1,0,0, 0,0,0,0,9,1);
        add(0,0,0,0, 0,0,0,0,9,1);
        add(0,0,1,2, 0,0,0,0,2,0);
        add(0,0,0,0, 1,1,2,'hA2,3,0);
        add(0,0,0,0, 1,1,2,'hA2,3,0);

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].rdy, vecs[k].rv, vecs[k].rpc);
            check($sformatf("vec%0d valid", k), 32'(out_valid), 32'(vecs[k].ev));
            check($sformatf("vec%0d adr", k),   32'(imem_adr),  32'(vecs[k].eadr));
            check($sformatf("vec%0d fault", k), 32'(fault),     32'(vecs[k].ef));
            if (vecs[k].cd) begin
                check($sformatf("vec%0d pc", k),    32'(out_pc), 32'(vecs[k].epc));
                check($sformatf("vec%0d instr", k), out_instr,   vecs[k].ei);
            end
        end

        // First valid appears on the first edge after the rst-deasserted edge.
        drive(1, 0, 0, '0);
        lat = -1;
        for (int c = 1; c <= 5 && lat < 0; c++) begin
            drive(0, 0, 0, '0);
            if (out_valid) lat = c;
        end
        check("first_valid_latency", 32'(lat), 32'd1);
        check("latency_pc", 32'(out_pc), 32'd0);
        check("latency_adr", 32'(imem_adr), 32'd1);

`ifdef IFETCH_PERF_EN
        drive(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, '0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, '0);
        drive(0, 1, 0, '0);
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stalled", perf_stalled, 32'd3);
        drive(1, 0, 0, '0);
        check("perf_fetched_rst", perf_fetched, 32'd0);
        check("perf_stalled_rst", perf_stalled, 32'd0);
`endif

        // Randomized traffic compared cycle by cycle against the model.
        drive(1, 0, 0, '0);
        for (int c = 0; c < 3000; c++) begin
            logic r, rdy, rv;
            logic [PC_W-1:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = PC_W'($urandom_range(0, 11));
            drive(r, rdy, rv, rpc);
            check($sformatf("rnd%0d valid", c), 32'(out_valid), 32'(m_valid));
            check($sformatf("rnd%0d adr", c),   32'(imem_adr),  32'(m_pc));
            check($sformatf("rnd%0d fault", c), 32'(fault),     32'(m_fault));
            if (m_valid) begin
                check($sformatf("rnd%0d pc", c),    32'(out_pc), 32'(m_opc));
                check($sformatf("rnd%0d instr", c), out_instr,   m_instr);
            end
`ifdef IFETCH_PERF_EN
            check($sformatf("rnd%0d fetched", c), perf_fetched, m_fetched);
            check($sformatf("rnd%0d stalled", c), perf_stalled, m_stalled);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that owns the program counter and drives the word address of the combinational-read program memory.
- Captures each returned instruction, together with its PC, into an output register.
- Hands the pair to the decode stage with a valid/ready handshake.
- Accepts jump/branch redirects from execute and flags fetches beyond memory depth.

Parameters:
- PC_W, 32: PC and memory-address width; PC counts instruction words, one per address.
- INSTR_W, 32: instruction word width.
- RESET_PC, 0: PC loaded on reset.
- MEM_DEPTH, 65536: number of valid instruction words; legal PC range is 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_adr  out  PC_W  address to program memory; equals the PC register (combinational from the register).
- imem_instr  in  INSTR_W  instruction returned combinationally for imem_adr in the same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  PC_W  absolute word target of the redirect.
- out_valid  out  1  out_instr/out_pc hold a fetched instruction.
- out_instr  out  INSTR_W  fetched instruction.
- out_pc  out  PC_W  address out_instr was fetched from.
- out_ready  in  1  decode accepts the output this cycle.
- fault  out  1  sticky; PC is outside 0..MEM_DEPTH-1.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, state=RUN. rst has priority over every other input.
- States are RUN and FAULT.
- adv = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- RUN, adv=1, pc<MEM_DEPTH: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1 (modulo 2^PC_W).
- RUN, adv=1, pc>=MEM_DEPTH: no capture, out_valid<=0, fault<=1, state<=FAULT, pc holds.
- Output stall (out_valid=1, out_ready=0, no redirect): out_instr, out_pc, out_valid and pc all hold.
- Handshake: a transfer occurs on an edge where out_valid&&out_ready. out_valid never drops without a transfer, except on redirect or rst.
- Redirect (any state): pc<=redirect_pc, out_valid<=0 (the held instruction is squashed even if out_ready=1 that cycle), fault<=0, state<=RUN. There is no capture in the redirect cycle; the target is captured on the following edge, giving a 1-cycle bubble.
- A redirect to an address >= MEM_DEPTH is accepted and faults on the next adv.
- Throughput: 1 instruction/cycle while out_ready=1.
- Latency: the first out_valid=1 appears on the first edge after the rst-deasserted edge.
- FAULT: the PC is frozen, out_valid=0, and only redirect or rst leave this state.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32 bits, +1 per capture) and perf_stalled (32 bits, +1 per cycle with out_valid&&!out_ready). Both clear on rst and saturate at all-ones.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared include alongside the existing opcode-macro header, holding:
  - state encodings FETCH_RUN=1'b0 and FETCH_FAULT=1'b1;
  - default RESET_PC and MEM_DEPTH constants, reused by the program memory sizing.
- One natural sub-module: fetch_pc_reg. It holds the PC register and the next-PC mux (hold / +1 / redirect) with the range compare. The output register and FSM stay in the top level.

Test Plan:
- Reset, then out_ready=1 with imem words 0..6 = 0xA0..0xA6 -> consecutive transfers (pc,instr)=(0,A0),(1,A1)...(6,A6), one per cycle, fault=0.
- Hold out_ready=0 for 3 cycles after (2,A2) is valid -> (2,A2) stays on the outputs and imem_adr stays 3; release -> (3,A3) follows the next cycle.
- Redirect to 1 while (4,A4) is valid and out_ready=1 -> A4 is not counted as transferred, one cycle has out_valid=0, then (1,A1),(2,A2) follow.
- MEM_DEPTH=8, run past pc 7 -> (7,A7) is transferred, then fault=1 and out_valid=0 with pc frozen at 8; a redirect to 0 clears fault and (0,A0) follows.
- Assert rst mid-stream while stalled on (5,A5) -> next cycle out_valid=0, pc=0, fault=0; after rst release (0,A0) follows.
- With IFETCH_PERF_EN: 4 transfers and 3 stall cycles -> perf_fetched=5 (including the held capture) and perf_stalled=3; both read 0 after rst.
